mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_timer.sv | 31 +++
 rtl/mem_stage.sv | 135 +++++++++++++
 tb/tb_mem_stage.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared processor definitions for the memory stage:
// FSM encoding, timeout default and the captured-op bundle.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_e;

    localparam int MEM_TIMEOUT = 15;

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] srcb;
        logic        rd;
        logic        wr;
        logic        dmp;
        logic [1:0]  regsrc;
        logic [15:0] npc;
        logic [15:0] wb;
    } mem_op_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage
// (master) and the data memory (slave).
interface mem_stage_if;

    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_busy;
    logic        mem_done;
    logic [15:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_busy, mem_done, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_busy, mem_done, mem_rdata
    );

endinterface

// File: rtl/mem_timer.sv
// 4-bit access timer: cleared on request entry, counts while busy,
// flags the cycle whose increment reaches TIMEOUT.
module mem_timer
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [3:0] LAST = 4'(TIMEOUT - 1);

    logic [3:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 4'd1;
        end
    end

    assign expired = enable & (count_q == LAST);

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores to data memory,
// waits for completion with a timeout and retires to writeback.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] alu_in,
    input  logic [15:0] srcb_in,
    input  logic        memwrt_in,
    input  logic        memread_in,
    input  logic        dmp_in,
    input  logic [1:0]  regsrc_in,
    input  logic [15:0] next_PC_in,
    input  logic [15:0] wb_in,
    output logic        stall_up,
    input  logic        out_stall,
    output logic        out_valid,
    output logic [15:0] alu_out,
    output logic [15:0] mem_data_out,
    output logic [15:0] next_PC_out,
    output logic [15:0] wb_out,
    output logic [1:0]  regsrc_out,
    output logic        halt,
    output logic        err,
    mem_stage_if.master mem
);

    mem_state_e state_q, state_d;
    mem_op_t    op_q, op_in, ret_op;

    logic accept, is_mem, misalign, go_req;
    logic fast_ret, done_ret, tmo, mem_ret, retire;
    logic busy_st, expired;

    assign busy_st  = (state_q != IDLE);
    assign stall_up = busy_st | (out_valid & out_stall) | halt;
    assign accept   = in_valid & ~stall_up;
    assign is_mem   = memread_in | memwrt_in;
    assign misalign = is_mem & alu_in[0];
    assign go_req   = accept & is_mem & ~alu_in[0];
    assign fast_ret = accept & ~go_req;

    // Completion beats the timer when both land on the same cycle.
    assign done_ret = (state_q == WAIT) & mem.mem_done;
    assign tmo      = expired & ~done_ret;
    assign mem_ret  = done_ret | tmo;
    assign retire   = fast_ret | mem_ret;

    assign op_in = '{
        alu:    alu_in,
        srcb:   srcb_in,
        rd:     memread_in,
        wr:     memwrt_in,
        dmp:    dmp_in,
        regsrc: regsrc_in,
        npc:    next_PC_in,
        wb:     wb_in
    };

    assign ret_op = mem_ret ? op_q : op_in;

    mem_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (go_req),
        .enable  (busy_st),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (go_req) state_d = REQ;
            REQ: begin
                if (tmo)                state_d = IDLE;
                else if (!mem.mem_busy) state_d = WAIT;
            end
            WAIT: if (mem_ret) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q <= '0;
        end else if (accept) begin
            op_q <= op_in;
        end
    end

    assign mem.mem_addr  = op_q.alu;
    assign mem.mem_wdata = op_q.srcb;
    assign mem.mem_rd    = (state_q == REQ) & op_q.rd;
    assign mem.mem_wr    = (state_q == REQ) & op_q.wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            alu_out      <= '0;
            mem_data_out <= '0;
            next_PC_out  <= '0;
            wb_out       <= '0;
            regsrc_out   <= '0;
            halt         <= 1'b0;
            err          <= 1'b0;
        end else if (retire) begin
            out_valid   <= 1'b1;
            alu_out     <= ret_op.alu;
            next_PC_out <= ret_op.npc;
            wb_out      <= ret_op.wb;
            regsrc_out  <= ret_op.regsrc;
            halt        <= halt | ret_op.dmp;
            err         <= err | (fast_ret & misalign) | tmo;
            // Stores and non-memory ops leave load data untouched.
            if (tmo)
                mem_data_out <= '0;
            else if (mem_ret & op_q.rd)
                mem_data_out <= mem.mem_rdata;
        end else if (!out_stall) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against an operation-level model.
module tb_mem_stage;

    import mem_stage_pkg::*;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] alu_in, srcb_in, next_PC_in, wb_in;
    logic        memwrt_in, memread_in, dmp_in;
    logic [1:0]  regsrc_in;
    logic        stall_up, out_stall, out_valid;
    logic [15:0] alu_out, mem_data_out, next_PC_out, wb_out;
    logic [1:0]  regsrc_out;
    logic        halt, err;

    mem_stage_if mif ();

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .alu_in       (alu_in),
        .srcb_in      (srcb_in),
        .memwrt_in    (memwrt_in),
        .memread_in   (memread_in),
        .dmp_in       (dmp_in),
        .regsrc_in    (regsrc_in),
        .next_PC_in   (next_PC_in),
        .wb_in        (wb_in),
        .stall_up     (stall_up),
        .out_stall    (out_stall),
        .out_valid    (out_valid),
        .alu_out      (alu_out),
        .mem_data_out (mem_data_out),
        .next_PC_out  (next_PC_out),
        .wb_out       (wb_out),
        .regsrc_out   (regsrc_out),
        .halt         (halt),
        .err          (err),
        .mem          (mif)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_mdo;
    logic        exp_err, exp_halt;

    task automatic idle_inputs;
        in_valid      = 1'b0;
        alu_in        = '0;
        srcb_in       = '0;
        next_PC_in    = '0;
        wb_in         = '0;
        memwrt_in     = 1'b0;
        memread_in    = 1'b0;
        dmp_in        = 1'b0;
        regsrc_in     = '0;
        out_stall     = 1'b0;
        mif.mem_busy  = 1'b0;
        mif.mem_done  = 1'b0;
        mif.mem_rdata = '0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        tests++;
        if ({out_valid, halt, err, mif.mem_rd, mif.mem_wr, stall_up} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 000000",
                     {out_valid, halt, err, mif.mem_rd, mif.mem_wr, stall_up});
        end
        tests++;
        if ({alu_out, mem_data_out, next_PC_out, wb_out, regsrc_out} !== 66'b0) begin
            fails++;
            $display("FAIL reset_data: got %h want 0",
                     {alu_out, mem_data_out, next_PC_out, wb_out, regsrc_out});
        end
        exp_mdo  = '0;
        exp_err  = 1'b0;
        exp_halt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    // One operation end to end: b busy cycles in REQ, done on the d-th
    // WAIT cycle, then st cycles of downstream back-pressure.
    task automatic run_op(input string nm,
                          input logic [15:0] alu, input logic [15:0] srcb,
                          input logic wr, input logic rd, input logic dmp,
                          input logic [1:0] rs,
                          input logic [15:0] npc, input logic [15:0] wb,
                          input int b, input int d, input int st,
                          input logic [15:0] rdv);
        logic al, mis, to;
        int kd, lat, exp_sc, k, sc, bad, su0, abad, sbad;
        logic [65:0] exp_v;
        al  = (rd | wr) & ~alu[0];
        mis = (rd | wr) & alu[0];
        kd  = b + 1 + d;
        to  = al && (kd > TO - 1);
        exp_sc = !al ? 0 : ((b + 1 < TO) ? b + 1 : TO);
        lat = !al ? 0 : (to ? TO : kd + 1);

        in_valid = 1'b1; alu_in = alu; srcb_in = srcb;
        memwrt_in = wr; memread_in = rd; dmp_in = dmp;
        regsrc_in = rs; next_PC_in = npc; wb_in = wb;
        #1;
        tests++;
        if (stall_up !== 1'b0) begin
            fails++;
            $display("FAIL %s accept_stall: got %b want 0", nm, stall_up);
        end
        @(negedge clk);
        in_valid = 1'b0;
        alu_in = 16'($urandom); srcb_in = 16'($urandom);
        next_PC_in = 16'($urandom); wb_in = 16'($urandom);
        regsrc_in = 2'($urandom); memwrt_in = 1'b0; memread_in = 1'b0;
        dmp_in = 1'b0;

        k = 0; sc = 0; bad = 0; su0 = 0; abad = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            if ((wr ? mif.mem_wr : mif.mem_rd) === 1'b1) sc++;
            if ((wr ? mif.mem_rd : mif.mem_wr) === 1'b1) bad++;
            if ((mif.mem_rd | mif.mem_wr) === 1'b1 &&
                (mif.mem_addr !== alu || (wr && mif.mem_wdata !== srcb)))
                abad++;
            if (stall_up !== 1'b1) su0++;
            mif.mem_busy  = (k < b);
            mif.mem_done  = (k == kd) || (k <= b && $urandom_range(0, 1) == 1);
            mif.mem_rdata = (k == kd) ? rdv : 16'($urandom);
            @(negedge clk);
            k++;
        end
        mif.mem_busy = 1'b0;
        mif.mem_done = 1'b0;

        if (al) exp_mdo = to ? 16'h0 : (rd ? rdv : exp_mdo);
        exp_err  = exp_err | mis | to;
        exp_halt = exp_halt | dmp;
        exp_v = {alu, npc, wb, rs, exp_mdo};

        tests++;
        if (k !== lat) begin
            fails++;
            $display("FAIL %s latency: got %0d want %0d", nm, k, lat);
        end
        tests++;
        if (sc !== exp_sc || bad !== 0) begin
            fails++;
            $display("FAIL %s strobes: got %0d (wrong %0d) want %0d", nm, sc, bad, exp_sc);
        end
        tests++;
        if (abad !== 0 || su0 !== 0) begin
            fails++;
            $display("FAIL %s busy_phase: addr errs %0d stall_up lows %0d want 0", nm, abad, su0);
        end
        tests++;
        if ({alu_out, next_PC_out, wb_out, regsrc_out, mem_data_out} !== exp_v) begin
            fails++;
            $display("FAIL %s outputs: got %h want %h", nm,
                     {alu_out, next_PC_out, wb_out, regsrc_out, mem_data_out}, exp_v);
        end
        tests++;
        if ({err, halt} !== {exp_err, exp_halt}) begin
            fails++;
            $display("FAIL %s err_halt: got %b want %b", nm, {err, halt}, {exp_err, exp_halt});
        end

        sbad = 0;
        out_stall = (st > 0);
        for (int i = 0; i < st; i++) begin
            #1;
            if (stall_up !== 1'b1 || out_valid !== 1'b1 ||
                {alu_out, next_PC_out, wb_out, regsrc_out, mem_data_out} !== exp_v)
                sbad++;
            @(negedge clk);
        end
        out_stall = 1'b0;
        #1;
        if (out_valid !== 1'b1) sbad++;
        @(negedge clk);
        tests++;
        if (sbad !== 0) begin
            fails++;
            $display("FAIL %s hold: got %0d bad cycles want 0", nm, sbad);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s handoff: got out_valid %b want 0", nm, out_valid);
        end
    endtask

    task automatic test_nonmem;
        run_op("nonmem_1234", 16'h1234, 16'h5555, 1'b0, 1'b0, 1'b0, 2'd1,
               16'h0102, 16'h0304, 0, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++)
            run_op("nonmem_rand", 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0,
                   2'($urandom), 16'($urandom), 16'($urandom), 0, 0, i, 16'h0);
    endtask

    task automatic test_load;
        run_op("load_beef", 16'h0040, 16'h0, 1'b0, 1'b1, 1'b0, 2'd2,
               16'h0044, 16'h0, 2, 2, 0, 16'hBEEF);
        run_op("store_ok", 16'h0042, 16'hCAFE, 1'b1, 1'b0, 1'b0, 2'd0,
               16'h0046, 16'h0, 1, 0, 0, 16'h1111);
    endtask

    task automatic test_misaligned;
        run_op("store_0041", 16'h0041, 16'hABCD, 1'b1, 1'b0, 1'b0, 2'd0,
               16'h0048, 16'h0, 0, 0, 0, 16'h0);
        run_op("load_odd", 16'h0103, 16'h0, 1'b0, 1'b1, 1'b0, 2'd2,
               16'h004A, 16'h0, 0, 0, 0, 16'h2222);
    endtask

    task automatic test_timeout;
        run_op("load_beef2", 16'h0050, 16'h0, 1'b0, 1'b1, 1'b0, 2'd2,
               16'h0050, 16'h0, 0, 0, 0, 16'hBEEF);
        run_op("timeout_wait", 16'h0060, 16'h0, 1'b0, 1'b1, 1'b0, 2'd2,
               16'h0052, 16'h0, 0, 100, 0, 16'h7777);
        run_op("done_at_limit", 16'h0062, 16'h0, 1'b0, 1'b1, 1'b0, 2'd2,
               16'h0054, 16'h0, 3, 10, 0, 16'h3C3C);
        run_op("timeout_edge", 16'h0064, 16'h0, 1'b0, 1'b1, 1'b0, 2'd2,
               16'h0056, 16'h0, 3, 11, 0, 16'h4D4D);
        run_op("timeout_busy", 16'h0066, 16'h9999, 1'b1, 1'b0, 1'b0, 2'd0,
               16'h0058, 16'h0, 20, 0, 0, 16'h0);
    endtask

    task automatic test_out_stall;
        run_op("stall_nonmem", 16'h0ABC, 16'h0, 1'b0, 1'b0, 1'b0, 2'd3,
               16'h0060, 16'h0F0F, 0, 0, 4, 16'h0);
        run_op("stall_load", 16'h0070, 16'h0, 1'b0, 1'b1, 1'b0, 2'd2,
               16'h0062, 16'h0, 1, 1, 4, 16'h5A5A);
    endtask

    task automatic test_back_to_back;
        logic [15:0] a, c;
        int bad;
        a = 16'($urandom);
        c = 16'($urandom);
        bad = 0;
        in_valid = 1'b1; memread_in = 1'b0; memwrt_in = 1'b0; dmp_in = 1'b0;
        alu_in = a;
        @(negedge clk);
        if (out_valid !== 1'b1 || alu_out !== a) bad++;
        alu_in = c;
        #1;
        if (stall_up !== 1'b0) bad++;
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || alu_out !== c || bad !== 0) begin
            fails++;
            $display("FAIL back_to_back: got valid %b alu %h errs %0d want 1 %h 0",
                     out_valid, alu_out, bad, c);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_handoff: got %b want 0", out_valid);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 30; n++) begin
            int t, b, d, st;
            logic [15:0] a;
            logic rd, wr;
            t  = $urandom_range(0, 3);
            a  = 16'($urandom);
            rd = 1'b0;
            wr = 1'b0;
            unique case (t)
                0: ;
                1: begin rd = 1'b1; a[0] = 1'b0; end
                2: begin wr = 1'b1; a[0] = 1'b0; end
                default: begin
                    rd = $urandom_range(0, 1) == 1;
                    wr = ~rd;
                    a[0] = 1'b1;
                end
            endcase
            b  = $urandom_range(0, 3);
            d  = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 4);
            st = $urandom_range(0, 2);
            run_op("random", a, 16'($urandom), wr, rd, 1'b0, 2'($urandom),
                   16'($urandom), 16'($urandom), b, d, st, 16'($urandom));
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        bad = 0;
        in_valid = 1'b1; memread_in = 1'b1; memwrt_in = 1'b0; dmp_in = 1'b0;
        alu_in = 16'h0080;
        @(negedge clk);
        in_valid = 1'b0; memread_in = 1'b0;
        mif.mem_busy = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({out_valid, stall_up, mif.mem_rd, mif.mem_wr, err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_mid_flags: got %b want 00000",
                     {out_valid, stall_up, mif.mem_rd, mif.mem_wr, err});
        end
        tests++;
        if ({alu_out, mem_data_out, next_PC_out, wb_out, regsrc_out} !== 66'b0) begin
            fails++;
            $display("FAIL reset_mid_data: got %h want 0",
                     {alu_out, mem_data_out, next_PC_out, wb_out, regsrc_out});
        end
        exp_mdo  = '0;
        exp_err  = 1'b0;
        exp_halt = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mif.mem_done = 1'b1;
        mif.mem_rdata = 16'hDEAD;
        @(negedge clk);
        mif.mem_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid !== 1'b0 || stall_up !== 1'b0 || mem_data_out !== 16'h0) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL reset_mid_after: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_halt;
        int bad;
        run_op("dmp", 16'h00F0, 16'h0, 1'b0, 1'b0, 1'b1, 2'd1,
               16'h0090, 16'h0001, 0, 0, 0, 16'h0);
        bad = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alu_in = 16'($urandom);
            #1;
            if (stall_up !== 1'b1 || out_valid !== 1'b0 || halt !== 1'b1) bad++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL halt_block: got %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_out_stall();
        test_reset_mid();
        test_random();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
